rr_arbiter_4_v: RTL and testbench

RR_ARBITER_4_V -- requirements
Module: rr_arbiter_4_v

---
 rtl/rr_arbiter_4_v_pkg.sv | 25 ++
 rtl/rr_arbiter_4_v_penc.sv | 21 ++
 rtl/rr_arbiter_4_v.sv | 117 +++++++++++
 tb/tb_rr_arbiter_4_v.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_v_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arbiter_4_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int CNT_W        = 8;   // holds MAX_HOLD-1 for MAX_HOLD up to 255
    localparam int MAX_HOLD_DEF = 16;

    // Rotate a request vector right so that line 'sh' lands on bit 0.
    function automatic logic [NUM_REQ-1:0] rotate_right(
        input logic [NUM_REQ-1:0] vec,
        input logic [ID_W-1:0]    sh
    );
        logic [2*NUM_REQ-1:0] dbl;
        dbl = {vec, vec} >> sh;
        return dbl[NUM_REQ-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter_4_v_penc.sv
// 4:2 priority encoder, line 0 highest priority, with an any-set flag.
module rr_arbiter_4_v_penc
    import rr_arbiter_4_v_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_vec,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);

    // Lowest set bit wins; index is 0 when nothing is set.
    always_comb begin
        o_idx   = 2'd0;
        o_valid = 1'b1;
        if (i_vec[0])      o_idx = 2'd0;
        else if (i_vec[1]) o_idx = 2'd1;
        else if (i_vec[2]) o_idx = 2'd2;
        else if (i_vec[3]) o_idx = 2'd3;
        else               o_valid = 1'b0;
    end

endmodule

// File: rtl/rr_arbiter_4_v.sv
// Round-robin arbiter for 4 requesters with hold limit and a mandatory
// one-cycle gap between owners. All outputs are registered.
module rr_arbiter_4_v
    import rr_arbiter_4_v_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_id,
    output logic               o_gnt_valid,
    output logic               o_timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] req_rot;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_valid;
    logic [ID_W-1:0]    winner;

    assign req_rot = rotate_right(i_req, ptr_q);

    rr_arbiter_4_v_penc u_penc (
        .i_vec   (req_rot),
        .o_idx   (enc_idx),
        .o_valid (enc_valid)
    );

    // 2-bit add wraps modulo 4, undoing the rotation.
    assign winner = enc_idx + ptr_q;

    // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                cnt_d = '0;
                if (enc_valid) begin
                    state_d     = ST_GRANT;
                    gnt_d       = 4'b0001 << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    ptr_d       = winner + 2'd1;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!i_req[gnt_id_q] || (cnt_q == HOLD_LAST)) begin
                    // Release; a still-asserted request means the hold limit hit.
                    state_d     = ST_GAP;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    timeout_d   = i_req[gnt_id_q];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_gnt_id    = gnt_id_q;
    assign o_gnt_valid = gnt_valid_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4_v.sv
// Bench for rr_arbiter_4_v: two instances (MAX_HOLD 4 and 16) share stimulus
// and are checked every cycle against a behavioural model, plus literals.
module tb_rr_arbiter_4_v;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    logic [3:0] gnt4, gnt16;
    logic [1:0] id4, id16;
    logic       vld4, vld16;
    logic       to4, to16;

    int checks;
    int failures;

    rr_arbiter_4_v #(.MAX_HOLD(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt4), .o_gnt_id(id4), .o_gnt_valid(vld4), .o_timeout(to4)
    );

    rr_arbiter_4_v #(.MAX_HOLD(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt16), .o_gnt_id(id16), .o_gnt_valid(vld16), .o_timeout(to16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner (-1 = none), grant cycles used so far,
    // first-choice requester for the next arbitration, timeout flag.
    int m_owner [2];
    int m_used  [2];
    int m_next  [2];
    int m_to    [2];
    int m_limit [2];

    initial begin
        m_limit[0] = 4;
        m_limit[1] = 16;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1; m_used[i] = 0; m_next[i] = 0; m_to[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_owner[i] = -1; m_used[i] = 0; m_next[i] = 0; m_to[i] = 0;
            end else if (m_owner[i] < 0) begin
                int pick;
                pick = -1;
                for (int j = 0; j < 4; j++) begin
                    int c;
                    c = (m_next[i] + j) % 4;
                    if (pick < 0 && req[c]) pick = c;
                end
                m_to[i] = 0;
                if (pick >= 0) begin
                    m_owner[i] = pick;
                    m_used[i]  = 1;
                    m_next[i]  = (pick + 1) % 4;
                end
            end else if (!req[m_owner[i]]) begin
                m_owner[i] = -1; m_to[i] = 0;
            end else if (m_used[i] == m_limit[i]) begin
                m_owner[i] = -1; m_to[i] = 1;
            end else begin
                m_used[i] = m_used[i] + 1;
                m_to[i]   = 0;
            end
        end
    end

    task automatic chk_model(input string nm, input int i, input logic [3:0] g,
                             input logic [1:0] id, input logic v, input logic t);
        logic [7:0] got, exp;
        got = {g, id, v, t};
        exp[7:4] = (m_owner[i] < 0) ? 4'b0000 : (4'b0001 << m_owner[i]);
        exp[3:2] = (m_owner[i] < 0) ? 2'd0 : 2'(m_owner[i]);
        exp[1]   = (m_owner[i] >= 0);
        exp[0]   = (m_to[i] != 0);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got gnt/id/vld/to=%b want %b", nm, $time, got, exp);
        end
        checks++;
        if (!$onehot0(g)) begin
            failures++;
            $display("FAIL %s_onehot t=%0t: got gnt=%b want at most one bit", nm, $time, g);
        end
    endtask

    task automatic chk_lit(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got gnt/id/vld/to=%b want %b", nm, $time, got, exp);
        end
    endtask

    // Drive one cycle, then check both instances against the model.
    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        #1;
        chk_model("model_mh4", 0, gnt4, id4, vld4, to4);
        chk_model("model_mh16", 1, gnt16, id16, vld16, to16);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        req      = 4'b0000;
        rst      = 1'b1;
        #2;

        // Reset state
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk_lit("reset_mh4",  {gnt4, id4, vld4, to4},     8'b0000_00_0_0);
        chk_lit("reset_mh16", {gnt16, id16, vld16, to16}, 8'b0000_00_0_0);

        // Scenario 1: 0110 after reset -> requester 1 after one edge
        step(4'b0110, 1'b0);
        chk_lit("s1_grant", {gnt4, id4, vld4, to4}, {4'b0010, 2'd1, 1'b1, 1'b0});
        step(4'b0000, 1'b0);
        chk_lit("s1_release", {gnt4, id4, vld4, to4}, 8'b0000_00_0_0);
        step(4'b0000, 1'b0);

        // Scenario 2: all requesting, MAX_HOLD 4 -> 4 grant cycles + 1 gap each
        step(4'b0000, 1'b1);
        for (int e = 1; e <= 25; e++) begin
            logic [3:0] eg;
            logic [1:0] eid;
            step(4'b1111, 1'b0);
            eid = 2'(((e - 1) / 5) % 4);
            eg  = 4'b0001 << eid;
            if (((e - 1) % 5) < 4)
                chk_lit("s2_grant", {gnt4, id4, vld4, to4}, {eg, eid, 1'b1, 1'b0});
            else
                chk_lit("s2_timeout", {gnt4, id4, vld4, to4}, 8'b0000_00_0_1);
        end

        // Scenario 3: requester 2 owns, drops while 3 requests
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        chk_lit("s3_own2", {gnt4, id4, vld4, to4}, {4'b0100, 2'd2, 1'b1, 1'b0});
        step(4'b1100, 1'b0);
        step(4'b1000, 1'b0);
        chk_lit("s3_gap", {gnt4, id4, vld4, to4}, 8'b0000_00_0_0);
        step(4'b1000, 1'b0);
        chk_lit("s3_own3", {gnt4, id4, vld4, to4}, {4'b1000, 2'd3, 1'b1, 1'b0});

        // Scenario 4: after requester 0 releases, 1001 picks requester 3
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk_lit("s4_own0", {gnt4, id4, vld4, to4}, {4'b0001, 2'd0, 1'b1, 1'b0});
        step(4'b1000, 1'b0);
        step(4'b1001, 1'b0);
        chk_lit("s4_own3", {gnt4, id4, vld4, to4}, {4'b1000, 2'd3, 1'b1, 1'b0});

        // Scenario 5: reset in the 3rd grant cycle, then 1111 grants 0
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        chk_lit("s5_rst_mh4",  {gnt4, id4, vld4, to4},     8'b0000_00_0_0);
        chk_lit("s5_rst_mh16", {gnt16, id16, vld16, to16}, 8'b0000_00_0_0);
        step(4'b1111, 1'b0);
        chk_lit("s5_regrant", {gnt4, id4, vld4, to4}, {4'b0001, 2'd0, 1'b1, 1'b0});
        // Reset during the timeout pulse
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        chk_lit("s5_pulse", {gnt4, id4, vld4, to4}, 8'b0000_00_0_1);
        step(4'b1111, 1'b1);
        chk_lit("s5_rst_pulse", {gnt4, id4, vld4, to4}, 8'b0000_00_0_0);
        step(4'b1111, 1'b0);
        chk_lit("s5_after", {gnt4, id4, vld4, to4}, {4'b0001, 2'd0, 1'b1, 1'b0});

        // Scenario 6: lone requester 1, MAX_HOLD 16
        step(4'b0000, 1'b1);
        for (int e = 1; e <= 18; e++) begin
            step(4'b0010, 1'b0);
            if (e <= 16 || e == 18)
                chk_lit("s6_grant", {gnt16, id16, vld16, to16}, {4'b0010, 2'd1, 1'b1, 1'b0});
            else
                chk_lit("s6_timeout", {gnt16, id16, vld16, to16}, 8'b0000_00_0_1);
        end

        step(4'b0000, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
